// File: rtl/weight_buffer_ctrl_pkg.sv
// Shared sizing, state encoding and command range checks for the weight buffer sequencer.
package weight_buffer_ctrl_pkg;

  localparam int dataWidth  = 32;
  localparam int featureLen = 256;
  localparam int psys       = 24;
  localparam int RD_LAT     = 2;

  localparam int DEPTH = featureLen * featureLen / psys;
  localparam int AW    = $clog2(DEPTH);
  localparam int DW    = dataWidth * psys;
  localparam int FD    = RD_LAT + 2;
  localparam int CW    = $clog2(FD + 1);
  localparam int PW    = (FD > 1) ? $clog2(FD) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_STREAM = 2'd2,
    S_DRAIN  = 2'd3
  } state_e;

  function automatic logic ld_len_ok(input logic [AW:0] len);
    return (len != '0) && (len <= (AW+1)'(DEPTH));
  endfunction

  // Sum is widened by one bit so base+len cannot wrap before the compare.
  function automatic logic rd_range_ok(input logic [AW-1:0] base, input logic [AW:0] len);
    logic [AW+1:0] last_excl;
    last_excl = (AW+2)'(base) + (AW+2)'(len);
    return (len != '0) && (last_excl <= (AW+2)'(DEPTH));
  endfunction

endpackage

// File: rtl/weight_stream_fifo.sv
// Small synchronous FIFO absorbing RAM read returns while the systolic array stalls.
module weight_stream_fifo
  import weight_buffer_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] din_i,
  input  logic          pop_i,
  output logic [DW-1:0] dout_o,
  output logic [CW-1:0] count_o
);

  logic [DW-1:0] mem_q [FD];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FD - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/weight_buffer_ctrl.sv
// Weight buffer sequencer: LOAD writes a streamed block from addr 0, STREAM reads a range
// out to the systolic array under valid/ready with credit-limited read issue.
module weight_buffer_ctrl
  import weight_buffer_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_start,
  input  logic [AW:0]   ld_len,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [DW-1:0] ld_data,
  input  logic          rd_start,
  input  logic [AW-1:0] rd_base,
  input  logic [AW:0]   rd_len,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          wb_enable,
  output logic          wb_writenable,
  output logic [AW-1:0] wb_addr,
  output logic [DW-1:0] wb_din,
  input  logic [DW-1:0] wb_dout
);

  state_e          state_q;
  logic            ld_ready_q, ld_fin_q, done_q, err_q;
  logic [AW:0]     ld_cnt_q, ld_len_q, iss_left_q, out_rem_q;
  logic            wb_enable_q, wb_writenable_q;
  logic [AW-1:0]   wb_addr_q;
  logic [DW-1:0]   wb_din_q;
  logic [RD_LAT-1:0] rd_vld_q;

  logic            issue_now, push, pop, ld_hs, can_issue_d;
  logic [7:0]      occ_d;
  logic [DW-1:0]   fifo_dout;
  logic [CW-1:0]   fifo_count;

  assign issue_now = wb_enable_q & ~wb_writenable_q;
  assign push      = rd_vld_q[RD_LAT-1];
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid & out_ready;
  assign ld_hs     = ld_valid & ld_ready_q;

  // Occupancy after this edge: FIFO plus every read still in the RAM pipe (including
  // the one issued now). A new issue is allowed only if it keeps the total within FD.
  always_comb begin
    occ_d = 8'(fifo_count) + 8'(issue_now) - 8'(pop);
    for (int i = 0; i < RD_LAT; i++) occ_d = occ_d + 8'(rd_vld_q[i]);
    can_issue_d = (occ_d < 8'(FD));
  end

  weight_stream_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (wb_dout),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (ld_hs) wb_din_q <= ld_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      ld_ready_q      <= 1'b0;
      ld_fin_q        <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
      ld_cnt_q        <= '0;
      ld_len_q        <= '0;
      iss_left_q      <= '0;
      out_rem_q       <= '0;
      wb_enable_q     <= 1'b0;
      wb_writenable_q <= 1'b0;
      wb_addr_q       <= '0;
      rd_vld_q        <= '0;
    end else begin
      done_q          <= 1'b0;
      wb_enable_q     <= 1'b0;
      wb_writenable_q <= 1'b0;
      rd_vld_q        <= RD_LAT'({rd_vld_q, issue_now});
      if (pop) out_rem_q <= out_rem_q - 1'b1;

      case (state_q)
        S_IDLE: begin
          if (ld_start) begin
            if (rd_start) err_q <= 1'b1;
            if (!ld_len_ok(ld_len)) begin
              err_q <= 1'b1;
            end else begin
              state_q    <= S_LOAD;
              ld_ready_q <= 1'b1;
              ld_cnt_q   <= '0;
              ld_len_q   <= ld_len;
            end
          end else if (rd_start) begin
            if (!rd_range_ok(rd_base, rd_len)) begin
              err_q <= 1'b1;
            end else begin
              wb_enable_q <= 1'b1;
              wb_addr_q   <= rd_base;
              iss_left_q  <= rd_len - 1'b1;
              out_rem_q   <= rd_len;
              state_q     <= (rd_len == (AW+1)'(1)) ? S_DRAIN : S_STREAM;
            end
          end
        end

        S_LOAD: begin
          if (ld_start || rd_start) err_q <= 1'b1;
          if (ld_fin_q) begin
            ld_fin_q <= 1'b0;
            state_q  <= S_IDLE;
            done_q   <= 1'b1;
          end else if (ld_hs) begin
            wb_enable_q     <= 1'b1;
            wb_writenable_q <= 1'b1;
            wb_addr_q       <= ld_cnt_q[AW-1:0];
            ld_cnt_q        <= ld_cnt_q + 1'b1;
            if (ld_cnt_q + 1'b1 == ld_len_q) begin
              ld_ready_q <= 1'b0;
              ld_fin_q   <= 1'b1;
            end
          end
        end

        S_STREAM: begin
          if (ld_start || rd_start) err_q <= 1'b1;
          if (can_issue_d) begin
            wb_enable_q <= 1'b1;
            wb_addr_q   <= wb_addr_q + 1'b1;
            iss_left_q  <= iss_left_q - 1'b1;
            if (iss_left_q == (AW+1)'(1)) state_q <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          if (ld_start || rd_start) err_q <= 1'b1;
          if (pop && out_rem_q == (AW+1)'(1)) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ld_ready      = ld_ready_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign err           = err_q;
  assign wb_enable     = wb_enable_q;
  assign wb_writenable = wb_writenable_q;
  assign wb_addr       = wb_addr_q;
  assign wb_din        = wb_writenable_q ? wb_din_q : '0;
  assign out_data      = out_valid ? fifo_dout : '0;
  assign out_last      = out_valid && (out_rem_q == (AW+1)'(1));

endmodule

// File: tb/tb_weight_buffer_ctrl.sv
// Directed + randomized bench for weight_buffer_ctrl with a behavioural RAM and expected-word model.
module tb_weight_buffer_ctrl;
  import weight_buffer_ctrl_pkg::*;

  logic          clk = 1'b0;
  logic          rst, ld_start, ld_valid, ld_ready, rd_start, out_valid, out_ready, out_last;
  logic          busy, done, err, wb_enable, wb_writenable;
  logic [AW:0]   ld_len, rd_len;
  logic [AW-1:0] rd_base, wb_addr;
  logic [DW-1:0] ld_data, out_data, wb_din, wb_dout;

  always #5 clk = ~clk;

  weight_buffer_ctrl dut (
    .clk(clk), .rst(rst), .ld_start(ld_start), .ld_len(ld_len), .ld_valid(ld_valid),
    .ld_ready(ld_ready), .ld_data(ld_data), .rd_start(rd_start), .rd_base(rd_base),
    .rd_len(rd_len), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done), .err(err), .wb_enable(wb_enable),
    .wb_writenable(wb_writenable), .wb_addr(wb_addr), .wb_din(wb_din), .wb_dout(wb_dout)
  );

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural weight RAM with RD_LAT-cycle read latency.
  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] rp [RD_LAT];
  always @(posedge clk) begin
    if (wb_enable && wb_writenable) ram[wb_addr] <= wb_din;
    rp[0] <= ram[wb_addr];
    for (int i = 1; i < RD_LAT; i++) rp[i] <= rp[i-1];
  end
  assign wb_dout = rp[RD_LAT-1];

  logic [DW-1:0] model_mem [DEPTH];

  logic [AW-1:0] wa_q[$];
  logic [DW-1:0] wd_q[$];
  int            wc_q[$];
  logic [DW-1:0] od_q[$];
  logic          ol_q[$];
  int            oc_q[$];
  int            dc_q[$];
  int            rd_total = 0, idle_acc = 0, unstable = 0, occ_viol = 0, iss_n = 0, pop_n = 0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] held;

  always @(negedge clk) begin
    if (wb_enable && wb_writenable) begin
      wa_q.push_back(wb_addr); wd_q.push_back(wb_din); wc_q.push_back(cyc);
    end
    if (wb_enable && !wb_writenable) rd_total <= rd_total + 1;
    if (wb_enable && !busy) idle_acc <= idle_acc + 1;
    if (out_valid && out_ready) begin
      od_q.push_back(out_data); ol_q.push_back(out_last); oc_q.push_back(cyc);
    end
    if (done) dc_q.push_back(cyc);
    if (!rst && stall_prev && (!out_valid || out_data !== held)) unstable <= unstable + 1;
    stall_prev <= out_valid && !out_ready && !rst;
    held <= out_data;
    if (rst) begin
      iss_n <= 0; pop_n <= 0;
    end else begin
      if (wb_enable && !wb_writenable) begin
        iss_n <= iss_n + 1;
        if (iss_n + 1 - pop_n > FD) occ_viol <= occ_viol + 1;
      end
      if (out_valid && out_ready) pop_n <= pop_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW/32; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  task automatic do_reset();
    rst = 1'b1; step(); step(); rst = 1'b0; step();
  endtask

  task automatic wait_done(input int d0, input int bound);
    int b = 0;
    while (dc_q.size() == d0 && b < bound) begin step(); b++; end
  endtask

  // rdmode: 0 none, 1 rd_start together with ld_start, 2 rd_start pulse mid-load.
  task automatic do_load(input int n, input logic [31:0] vpat, input int rdmode);
    int w0, d0, taken, k;
    int hs_c[$];
    w0 = wa_q.size(); d0 = dc_q.size();
    ld_start = 1'b1; ld_len = (AW+1)'(n);
    rd_start = (rdmode == 1); rd_base = '0; rd_len = (AW+1)'(1);
    step();
    ld_start = 1'b0; rd_start = 1'b0;
    taken = 0; k = 0;
    while (taken < n && k < 4*n + 64) begin
      ld_valid = (k < 32) ? vpat[k] : 1'b1;
      ld_data  = rand_word();
      rd_start = (rdmode == 2) && (k == 1);
      if (ld_valid && ld_ready) begin
        model_mem[taken] = ld_data; hs_c.push_back(cyc); taken++;
      end
      step(); k++;
    end
    ld_valid = 1'b0; rd_start = 1'b0;
    wait_done(d0, 10);
    step();
    chk("ld_taken", DW'(taken), DW'(n));
    chk("ld_nwrites", DW'(wa_q.size() - w0), DW'(n));
    for (int i = 0; i < n && i < wa_q.size() - w0; i++) begin
      chk($sformatf("ld_addr%0d", i), DW'(wa_q[w0+i]), DW'(i));
      chk($sformatf("ld_data%0d", i), wd_q[w0+i], model_mem[i]);
      chk($sformatf("ld_wcyc%0d", i), DW'(wc_q[w0+i]), DW'(hs_c[i] + 1));
    end
    chk("ld_done_n", DW'(dc_q.size() - d0), DW'(1));
    if (dc_q.size() > d0 && taken == n) chk("ld_done_cyc", DW'(dc_q[d0]), DW'(hs_c[n-1] + 2));
    chk("ld_ready_after", DW'(ld_ready), DW'(0));
    chk("ld_busy_after", DW'(busy), DW'(0));
  endtask

  task automatic do_stream(input int base, input int len, input int stall_at, input int stall_n,
                           input bit rnd);
    int o0, d0, w0, s, k, n;
    o0 = od_q.size(); d0 = dc_q.size(); w0 = wa_q.size();
    s = cyc;
    rd_start = 1'b1; rd_base = AW'(base); rd_len = (AW+1)'(len); out_ready = 1'b1;
    step();
    rd_start = 1'b0;
    k = 0;
    while (dc_q.size() == d0 && k < 40*len + 100) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : !(k >= stall_at && k < stall_at + stall_n);
      step(); k++;
    end
    out_ready = 1'b1;
    step();
    n = od_q.size() - o0;
    chk("st_nwords", DW'(n), DW'(len));
    for (int i = 0; i < len && i < n; i++) begin
      chk($sformatf("st_data%0d", i), od_q[o0+i], model_mem[base+i]);
      chk($sformatf("st_last%0d", i), DW'(ol_q[o0+i]), DW'(i == len - 1));
      if (stall_n == 0 && !rnd)
        chk($sformatf("st_cyc%0d", i), DW'(oc_q[o0+i]), DW'(s + RD_LAT + 2 + i));
    end
    chk("st_done_n", DW'(dc_q.size() - d0), DW'(1));
    if (dc_q.size() > d0 && n > 0) chk("st_done_cyc", DW'(dc_q[d0]), DW'(oc_q[o0+n-1] + 1));
    chk("st_no_write", DW'(wa_q.size() - w0), DW'(0));
    chk("st_credit", DW'(occ_viol), DW'(0));
    chk("st_stable", DW'(unstable), DW'(0));
    chk("st_busy_after", DW'(busy), DW'(0));
  endtask

  initial begin
    int d0, r0, b, l;
    rst = 1'b1; ld_start = 1'b0; ld_len = '0; ld_valid = 1'b0; ld_data = '0;
    rd_start = 1'b0; rd_base = '0; rd_len = '0; out_ready = 1'b1;
    step(); step();
    chk("rst_busy", DW'(busy), DW'(0));
    chk("rst_done", DW'(done), DW'(0));
    chk("rst_err", DW'(err), DW'(0));
    chk("rst_ld_ready", DW'(ld_ready), DW'(0));
    chk("rst_out_valid", DW'(out_valid), DW'(0));
    chk("rst_out_last", DW'(out_last), DW'(0));
    chk("rst_wb_en", DW'({wb_enable, wb_writenable}), DW'(0));
    chk("rst_wb_addr", DW'(wb_addr), DW'(0));
    chk("rst_out_data", out_data, DW'(0));
    chk("rst_wb_din", wb_din, DW'(0));
    rst = 1'b0; step();

    do_load(4, 32'hFFFF_FFFD, 0);
    chk("ld4_err", DW'(err), DW'(0));
    do_load(8, $urandom(), 0);
    do_stream(2, 5, 0, 0, 1'b0);
    do_stream(2, 5, 5, 10, 1'b0);
    do_load(64, $urandom(), 0);
    do_stream(7, 1, 0, 0, 1'b0);
    for (int t = 0; t < 4; t++) begin
      l = $urandom_range(1, 20);
      b = $urandom_range(0, 64 - l);
      do_stream(b, l, 0, 0, 1'b1);
    end
    chk("err_clean", DW'(err), DW'(0));

    // Out-of-range stream is rejected with no RAM traffic.
    r0 = rd_total; d0 = dc_q.size();
    rd_start = 1'b1; rd_base = AW'(2728); rd_len = (AW+1)'(3);
    step(); rd_start = 1'b0;
    chk("oor_busy", DW'(busy), DW'(0));
    for (int i = 0; i < 5; i++) step();
    chk("oor_err", DW'(err), DW'(1));
    chk("oor_busy2", DW'(busy), DW'(0));
    chk("oor_no_read", DW'(rd_total - r0), DW'(0));
    chk("oor_no_done", DW'(dc_q.size() - d0), DW'(0));

    do_reset();
    chk("rst_err_clr", DW'(err), DW'(0));
    d0 = dc_q.size();
    ld_start = 1'b1; ld_len = '0; step(); ld_start = 1'b0; step();
    chk("ld0_err", DW'(err), DW'(1));
    chk("ld0_busy", DW'(busy), DW'(0));
    do_reset();
    ld_start = 1'b1; ld_len = (AW+1)'(DEPTH + 1); step(); ld_start = 1'b0; step(); step();
    chk("ldbig_err", DW'(err), DW'(1));
    chk("ldbig_busy", DW'(busy), DW'(0));
    chk("ldbig_no_done", DW'(dc_q.size() - d0), DW'(0));

    do_reset();
    do_load(6, 32'hFFFF_FFFF, 2);
    chk("rd_in_load_err", DW'(err), DW'(1));

    do_reset();
    r0 = od_q.size();
    do_load(5, $urandom(), 1);
    chk("both_start_err", DW'(err), DW'(1));
    chk("both_start_no_out", DW'(od_q.size() - r0), DW'(0));

    // Asynchronous reset in the middle of a stream.
    do_reset();
    d0 = dc_q.size();
    rd_start = 1'b1; rd_base = '0; rd_len = (AW+1)'(5); out_ready = 1'b1;
    step(); rd_start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("mid_busy_pre", DW'(busy), DW'(1));
    rst = 1'b1; #1;
    chk("mid_busy", DW'(busy), DW'(0));
    chk("mid_out_valid", DW'({out_valid, out_last}), DW'(0));
    chk("mid_wb", DW'({wb_enable, wb_writenable}), DW'(0));
    chk("mid_out_data", out_data, DW'(0));
    chk("mid_wb_addr", DW'(wb_addr), DW'(0));
    step(); step(); rst = 1'b0; step(); step();
    chk("mid_no_done", DW'(dc_q.size() - d0), DW'(0));
    chk("mid_out_idle", DW'(out_valid), DW'(0));
    do_stream(0, 5, 0, 0, 1'b0);
    chk("idle_access", DW'(idle_acc), DW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
